// File: rtl/group_update_sequencer.sv
// Sequences the colour-group select for the grouped p-bit update-order LUT:
// holds each group for H cycles, runs N sweeps (or free-runs) and reports progress.
module group_update_sequencer #(
  parameter int unsigned NUM_GROUPS = 5,
  parameter int unsigned GROUP_W    = 3,
  parameter int unsigned HOLD_W     = 8,
  parameter int unsigned SWEEP_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [HOLD_W-1:0]  hold_cycles,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic [GROUP_W-1:0] group_EN,
  output logic               group_valid,
  output logic               busy,
  output logic               sweep_done,
  output logic [SWEEP_W-1:0] sweep_count,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(NUM_GROUPS - 1);

  state_e             state_q, state_d;
  logic [GROUP_W-1:0] group_q, group_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [HOLD_W-1:0]  h_q, h_d;
  logic [SWEEP_W-1:0] n_q, n_d;
  logic [SWEEP_W-1:0] cnt_q, cnt_d;
  logic               sweep_done_q, sweep_done_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               last_sweep;

  // Next-state logic; the registered sweep_done flags the last cycle of the final group.
  always_comb begin
    state_d    = state_q;
    group_d    = group_q;
    hold_d     = hold_q;
    h_d        = h_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    last_sweep = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          h_d     = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
          n_d     = num_sweeps;
          cnt_d   = '0;
          group_d = '0;
          hold_d  = '0;
        end
      end
      RUN: begin
        if (sweep_done_q && (cnt_q != '1)) cnt_d = cnt_q + SWEEP_W'(1);
        if (hold_q == h_q - HOLD_W'(1)) begin
          hold_d  = '0;
          group_d = (group_q == LAST_GROUP) ? '0 : group_q + GROUP_W'(1);
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
        end
        last_sweep = sweep_done_q && (n_q != '0) && (cnt_d == n_q);
        if (abort || last_sweep) begin
          state_d = DONE;
          group_d = '0;
          hold_d  = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next-state values so they appear in the same cycle as the state.
    sweep_done_d = (state_d == RUN) && (group_d == LAST_GROUP) &&
                   (hold_d == h_d - HOLD_W'(1));
    valid_d      = (state_d == RUN);
    busy_d       = (state_d == RUN);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      group_q      <= '0;
      hold_q       <= '0;
      h_q          <= HOLD_W'(1);
      n_q          <= '0;
      cnt_q        <= '0;
      sweep_done_q <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      group_q      <= group_d;
      hold_q       <= hold_d;
      h_q          <= h_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      sweep_done_q <= sweep_done_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign group_EN    = group_q;
  assign group_valid = valid_q;
  assign busy        = busy_q;
  assign sweep_done  = sweep_done_q;
  assign sweep_count = cnt_q;
  assign done        = done_q;

endmodule

// File: tb/tb_group_update_sequencer.sv
// Self-checking bench for group_update_sequencer: table-driven runs checked
// cycle by cycle against a scoreboard queue, plus reset and start/abort corner cases.
module tb_group_update_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  hold_cycles;
  logic [15:0] num_sweeps;
  logic [2:0]  group_EN;
  logic        group_valid;
  logic        busy;
  logic        sweep_done;
  logic [15:0] sweep_count;
  logic        done;

  group_update_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .hold_cycles (hold_cycles),
    .num_sweeps  (num_sweeps),
    .group_EN    (group_EN),
    .group_valid (group_valid),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .sweep_count (sweep_count),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  g;
    logic        v;
    logic        b;
    logic        sd;
    logic        d;
    logic [15:0] cnt;
  } exp_t;

  // h, n: programmed values; abort_k: abort held during valid cycle k (0 = none);
  // st_k: observation index at which a stray start is pulsed (-1 = none).
  typedef struct {
    int h;
    int n;
    int abort_k;
    int st_k;
  } vec_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_out(input string name, input exp_t e);
    exp_t a;
    a = {group_EN, group_valid, busy, sweep_done, done, sweep_count};
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got g=%0d v=%0d busy=%0d sd=%0d done=%0d cnt=%0d, expected g=%0d v=%0d busy=%0d sd=%0d done=%0d cnt=%0d",
               name, a.g, a.v, a.b, a.sd, a.d, a.cnt, e.g, e.v, e.b, e.sd, e.d, e.cnt);
    end
  endtask

  function automatic exp_t mk(input int g, input int v, input int sd, input int d, input int cnt);
    exp_t e;
    e.g   = 3'(g);
    e.v   = 1'(v);
    e.b   = 1'(v);
    e.sd  = 1'(sd);
    e.d   = 1'(d);
    e.cnt = 16'(cnt);
    return e;
  endfunction

  task automatic run(input vec_t tv, input string name);
    int   he;
    int   sw;
    int   len;
    int   idx;
    exp_t e;
    he  = (tv.h == 0) ? 1 : tv.h;
    sw  = 5 * he;
    len = (tv.n == 0) ? tv.abort_k : tv.n * sw;
    if (tv.abort_k != 0 && tv.abort_k < len) len = tv.abort_k;
    @(negedge clk);
    start       = 1'b1;
    abort       = 1'b0;
    hold_cycles = 8'(tv.h);
    num_sweeps  = 16'(tv.n);
    for (int i = 0; i < len; i++)
      exp_q.push_back(mk((i / he) % 5, 1, (i % sw == sw - 1) ? 1 : 0, 0, i / sw));
    exp_q.push_back(mk(0, 0, 0, 1, len / sw));
    exp_q.push_back(mk(0, 0, 0, 0, len / sw));
    exp_q.push_back(mk(0, 0, 0, 0, len / sw));
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_out($sformatf("%s[%0d]", name, idx), e);
      start = (idx == tv.st_k);
      abort = (tv.abort_k != 0 && idx == tv.abort_k - 1);
      idx++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{h: 1, n: 1, abort_k: 0,  st_k: -1};
    tbl[1] = '{h: 3, n: 2, abort_k: 0,  st_k: -1};
    tbl[2] = '{h: 0, n: 1, abort_k: 0,  st_k: -1};
    tbl[3] = '{h: 2, n: 0, abort_k: 47, st_k: -1};
    tbl[4] = '{h: 1, n: 0, abort_k: 10, st_k: -1};
    tbl[5] = '{h: 4, n: 1, abort_k: 0,  st_k: 2};
    tbl[6] = '{h: 1, n: 1, abort_k: 0,  st_k: 5};
    tbl[7] = '{h: 2, n: 3, abort_k: 13, st_k: -1};
    tbl[8] = '{h: 1, n: 1, abort_k: 5,  st_k: -1};

    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    hold_cycles = 8'd0;
    num_sweeps  = 16'd0;
    @(negedge clk);
    check_out("reset", mk(0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start       = 1'b1;
    abort       = 1'b1;
    hold_cycles = 8'd1;
    num_sweeps  = 16'd1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_out("start_abort_idle", mk(0, 0, 0, 0, 0));
    @(negedge clk);
    check_out("start_abort_idle2", mk(0, 0, 0, 0, 0));

    for (int i = 0; i < 9; i++) run(tbl[i], $sformatf("vec%0d", i));

    // asynchronous reset in the middle of a free run
    @(negedge clk);
    start       = 1'b1;
    hold_cycles = 8'd5;
    num_sweeps  = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check_out("rst_run_first", mk(0, 1, 0, 0, 0));
    repeat (26) @(negedge clk);
    check_out("pre_reset", mk(0, 1, 0, 0, 1));
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", mk(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_out("post_reset_no_done", mk(0, 0, 0, 0, 0));
    run('{h: 5, n: 1, abort_k: 0, st_k: -1}, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
